pcie_rq_mfb_arbiter: RTL
========================

Name: pcie_rq_mfb_arbiter

Overview:
- Shares one single-region PCIe RQ MFB stream between REQ_NUM requesters, e.g. DMA channel engines and the MI-to-PCIe bridge.
- Arbitration is round-robin with packet lock: a grant holds from SOF to EOF.
- On each SOF beat, the block packs the granted requester's header, prefix, FBE and LBE into the RQ meta word.
- The output register stage feeds the PCIe core adapter.

Parameters:
REQ_NUM, 4, number of requesters (2..16)
DATA_W, 512, MFB data width in bits
HDR_W, 128, request header width
PREFIX_W, 32, TLP prefix width
BE_W, 4, width of each of FBE and LBE
META_W, 168, output meta width (= HDR_W+PREFIX_W+2*BE_W)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
RX_DATA  in  REQ_NUM*DATA_W  requester data, requester i in slice i
RX_HDR  in  REQ_NUM*HDR_W  request header, valid on SOF beat
RX_PREFIX  in  REQ_NUM*PREFIX_W  TLP prefix, valid on SOF beat
RX_FBE  in  REQ_NUM*BE_W  first byte enable, valid on SOF beat
RX_LBE  in  REQ_NUM*BE_W  last byte enable, valid on SOF beat
RX_SOF  in  REQ_NUM  start of packet
RX_EOF  in  REQ_NUM  end of packet
RX_SRC_RDY  in  REQ_NUM  beat valid
RX_DST_RDY  out  REQ_NUM  beat accepted
TX_DATA  out  DATA_W  output data
TX_META  out  META_W  packed meta: HDR [127:0], PREFIX [159:128], FBE [163:160], LBE [167:164]
TX_SOF  out  1  start of packet
TX_EOF  out  1  end of packet
TX_SRC_RDY  out  1  output valid
TX_DST_RDY  in  1  output ready
TX_PKT_CNT  out  32  count of packets sent (EOF transfers on TX)
PROTO_ERR  out  1  sticky flag: SOF seen while locked, or non-SOF valid from the locked requester's peers ignored is not an error

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, rr_ptr=0, TX_SRC_RDY=0, TX_SOF=0, TX_EOF=0, TX_DATA=0, TX_META=0, TX_PKT_CNT=0, PROTO_ERR=0. RX_DST_RDY=0 while in reset.
- Reset mid-packet drops the partial packet. After reset, arbitration restarts from requester 0.
- Advance condition: adv = !TX_SRC_RDY | TX_DST_RDY. A beat of requester i transfers when RX_SRC_RDY[i] & RX_DST_RDY[i].
- IDLE state:
  - Candidates are requesters with RX_SRC_RDY & RX_SOF.
  - Select the first candidate at or above rr_ptr, wrapping modulo REQ_NUM. This is combinational.
  - RX_DST_RDY[sel] = adv. All other RX_DST_RDY bits are 0.
  - A valid beat without SOF in IDLE is never accepted (held off, not an error).
  - On a SOF transfer without EOF, latch gnt=sel and go to LOCKED.
  - On a transfer with SOF&EOF (single beat), stay in IDLE and set rr_ptr=sel+1 mod REQ_NUM.
- LOCKED state:
  - RX_DST_RDY[gnt] = adv. All others are 0.
  - On an EOF transfer, go to IDLE and set rr_ptr=gnt+1 mod REQ_NUM.
  - If a transfer from gnt carries SOF, still accept it and set PROTO_ERR=1 (sticky until reset).
- Output register, on adv:
  - TX_SRC_RDY <= transfer occurred.
  - TX_DATA, TX_SOF, TX_EOF <= the transferred beat.
  - TX_META <= packed meta on a SOF transfer. Otherwise TX_META holds its previous value; it is meaningful only when TX_SOF=1.
  - If adv=0, all TX outputs hold (no change while stalled).
- Latency: 1 cycle from RX transfer to TX_SRC_RDY. Full throughput of one beat per cycle while TX_DST_RDY=1. Back-to-back packets from different requesters need no idle cycle.
- TX_PKT_CNT increments on TX_SRC_RDY & TX_DST_RDY & TX_EOF and wraps at 2^32-1 → 0.
- No requester starves: at most REQ_NUM-1 packets from other requesters are granted before a waiting SOF requester.

Test Plan:
- Reset values: RESET_N=0 asserted mid-packet → all TX outputs 0, RX_DST_RDY=0. After release, requester 0 with SOF is granted first and the counter restarts at 0.
- Meta packing: REQ_NUM=4, requester 2 sends a 3-beat packet with HDR=0x0123..EF, PREFIX=0xA5A5A5A5, FBE=0xF, LBE=0x3 → TX shows 3 beats starting 1 cycle later. TX_META[159:128]=0xA5A5A5A5, [163:160]=0xF, [167:164]=0x3. TX_PKT_CNT=1.
- Round-robin fairness: all 4 requesters send continuous single-beat SOF&EOF packets → TX order 0,1,2,3,0,1… with no gap cycles.
- Packet lock: requester 1 sends a 5-beat packet while requester 0 asserts SOF → RX_DST_RDY[0]=0 until requester 1's EOF transfers. Requester 0 is granted on the next cycle and no beats interleave.
- Backpressure: TX_DST_RDY toggles 1,0,0,1 during a 4-beat packet → TX_DATA/TX_META stable while stalled, no beat lost or duplicated, RX_DST_RDY low exactly when TX_SRC_RDY=1 & TX_DST_RDY=0.
- Protocol error: requester 3 sends SOF while locked on requester 3 mid-packet → beat accepted, PROTO_ERR=1 and stays 1 until RESET_N=0.

Source files
------------

// File: rtl/pcie_rq_mfb_arbiter.sv
// rtl/pcie_rq_mfb_arbiter.sv - round-robin, packet-locked merge of REQ_NUM MFB request streams onto one PCIe RQ stream
// Packs header/prefix/FBE/LBE into TX_META on SOF beats; one output register stage.
module pcie_rq_mfb_arbiter #(
    parameter int REQ_NUM  = 4,
    parameter int DATA_W   = 512,
    parameter int HDR_W    = 128,
    parameter int PREFIX_W = 32,
    parameter int BE_W     = 4,
    parameter int META_W   = HDR_W + PREFIX_W + 2*BE_W
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [REQ_NUM*DATA_W-1:0]     RX_DATA,
    input  logic [REQ_NUM*HDR_W-1:0]      RX_HDR,
    input  logic [REQ_NUM*PREFIX_W-1:0]   RX_PREFIX,
    input  logic [REQ_NUM*BE_W-1:0]       RX_FBE,
    input  logic [REQ_NUM*BE_W-1:0]       RX_LBE,
    input  logic [REQ_NUM-1:0]            RX_SOF,
    input  logic [REQ_NUM-1:0]            RX_EOF,
    input  logic [REQ_NUM-1:0]            RX_SRC_RDY,
    output logic [REQ_NUM-1:0]            RX_DST_RDY,
    output logic [DATA_W-1:0]             TX_DATA,
    output logic [META_W-1:0]             TX_META,
    output logic                          TX_SOF,
    output logic                          TX_EOF,
    output logic                          TX_SRC_RDY,
    input  logic                          TX_DST_RDY,
    output logic [31:0]                   TX_PKT_CNT,
    output logic                          PROTO_ERR
);
    localparam int PTR_W = $clog2(REQ_NUM);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [PTR_W-1:0]   r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0]   w_sel, w_port;
    logic               w_sel_vld, w_adv, w_xfer, w_sof, w_eof;
    logic               r_proto_err, w_proto_nxt;
    logic [REQ_NUM-1:0] w_cand, w_dst_rdy;
    logic [DATA_W-1:0]  w_data;
    logic [META_W-1:0]  w_meta;

    logic               r_tx_src_rdy, r_tx_sof, r_tx_eof;
    logic [DATA_W-1:0]  r_tx_data;
    logic [META_W-1:0]  r_tx_meta;
    logic [31:0]        r_pkt_cnt;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_NUM-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_adv  = !r_tx_src_rdy | TX_DST_RDY;
    assign w_cand = RX_SRC_RDY & RX_SOF;

    // Descending scan so the last hit is the first candidate at/after rr_ptr.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int k = REQ_NUM-1; k >= 0; k--) begin
            if (w_cand[PTR_W'((int'(r_rr_ptr) + k) % REQ_NUM)]) begin
                w_sel     = PTR_W'((int'(r_rr_ptr) + k) % REQ_NUM);
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_port = (r_state == ST_IDLE) ? w_sel : r_gnt;
    assign w_xfer = w_adv & RX_SRC_RDY[w_port] & ((r_state == ST_LOCKED) | w_sel_vld);

    always_comb begin
        w_data = '0;
        w_meta = '0;
        w_sof  = 1'b0;
        w_eof  = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_port == PTR_W'(i)) begin
                w_data = RX_DATA[i*DATA_W +: DATA_W];
                w_sof  = RX_SOF[i];
                w_eof  = RX_EOF[i];
                w_meta = {RX_LBE[i*BE_W +: BE_W], RX_FBE[i*BE_W +: BE_W],
                          RX_PREFIX[i*PREFIX_W +: PREFIX_W], RX_HDR[i*HDR_W +: HDR_W]};
            end
        end
    end

    always_comb begin
        w_dst_rdy = '0;
        if ((r_state == ST_LOCKED) || w_sel_vld) begin
            w_dst_rdy[w_port] = w_adv;
        end
    end

    assign RX_DST_RDY = RESET_N ? w_dst_rdy : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        w_proto_nxt = r_proto_err;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_eof) begin
                        w_rr_nxt = f_inc(w_sel);
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_gnt_nxt   = w_sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    if (w_sof) begin
                        w_proto_nxt = 1'b1;
                    end
                    if (w_eof) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = f_inc(r_gnt);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_proto_err <= w_proto_nxt;
        end
    end

    // Output stage only moves on adv, so everything holds while the core stalls.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_src_rdy <= 1'b0;
            r_tx_sof     <= 1'b0;
            r_tx_eof     <= 1'b0;
            r_tx_data    <= '0;
            r_tx_meta    <= '0;
        end else if (w_adv) begin
            r_tx_src_rdy <= w_xfer;
            if (w_xfer) begin
                r_tx_sof  <= w_sof;
                r_tx_eof  <= w_eof;
                r_tx_data <= w_data;
                if (w_sof) begin
                    r_tx_meta <= w_meta;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pkt_cnt <= '0;
        end else if (r_tx_src_rdy && TX_DST_RDY && r_tx_eof) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign TX_SRC_RDY = r_tx_src_rdy;
    assign TX_SOF     = r_tx_sof;
    assign TX_EOF     = r_tx_eof;
    assign TX_DATA    = r_tx_data;
    assign TX_META    = r_tx_meta;
    assign TX_PKT_CNT = r_pkt_cnt;
    assign PROTO_ERR  = r_proto_err;
endmodule
